jtag_er1_mailbox: RTL and testbench

Command/response mailbox on the JTAGG ER1 user data register (instruction 0x32), clocked entirely in the JTCK domain. It consumes the JTAGG primitive's ER1 strobes (JCE1, JSHIFT, JUPDATE, JTDI) and drives JTDO1 back into it. A host shifts in a {write, addr, data} frame, which is delivered to fabric logic as a valid/ready command. On the next capture, the host reads back the latest response word plus sticky status flags.

---
 rtl/jtag_er1_mailbox_pkg.sv | 20 ++
 rtl/jtag_er1_mailbox_if.sv | 23 ++
 rtl/jtag_er1_mailbox_shreg.sv | 34 +++
 rtl/jtag_er1_mailbox.sv | 164 ++++++++++++++++
 tb/tb_jtag_er1_mailbox.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/jtag_er1_mailbox_pkg.sv
// Shared definitions for the JTAG ER1 mailbox: frame sizing, status flag offsets, scan FSM states.
package jtag_er1_pkg;

    localparam int unsigned FLAG_RSP  = 0;
    localparam int unsigned FLAG_PEND = 1;
    localparam int unsigned FLAG_OVF  = 2;
    localparam int unsigned FLAG_LEN  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAPT  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    // Frame is {write, addr, data}
    function automatic int unsigned frame_width(input int unsigned addr_w, input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/jtag_er1_mailbox_if.sv
// Command/response bus between the ER1 mailbox and fabric logic.
interface jtag_er1_mailbox_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 24
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_data,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/jtag_er1_mailbox_shreg.sv
// ER1 data shift register (LSB first) with a saturating shifted-bit counter.
module jtag_er1_shreg #(
    parameter int unsigned FRAME_W = 32,
    parameter int unsigned CNT_W   = $clog2(FRAME_W + 2)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               capture,
    input  logic [FRAME_W-1:0] load,
    input  logic               shift_en,
    input  logic               tdi,
    output logic [FRAME_W-1:0] sr,
    output logic [CNT_W-1:0]   count
);

    // Saturating one past a full frame so over-long scans read as a length error
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_W + 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr    <= '0;
            count <= '0;
        end else if (capture) begin
            sr    <= load;
            count <= '0;
        end else if (shift_en) begin
            sr <= {tdi, sr[FRAME_W-1:1]};
            if (count != CNT_MAX) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/jtag_er1_mailbox.sv
// JTAGG ER1 command/response mailbox, entirely in the JTCK domain.
module jtag_er1_mailbox
    import jtag_er1_pkg::*;
#(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 24
) (
    input  logic                 jtck,
    input  logic                 jrstn,
    input  logic                 jtdi,
    input  logic                 jshift,
    input  logic                 jupdate,
    input  logic                 jce1,
    output logic                 jtdo1,
    jtag_er1_mailbox_if.master   bus
);

    localparam int unsigned FRAME_W = frame_width(ADDR_W, DATA_W);
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

    state_t              state_q, state_d;
    logic [FRAME_W-1:0]  sr;
    logic [FRAME_W-1:0]  cap_word;
    logic [CNT_W-1:0]    count;

    logic                cmd_valid_q;
    logic                cmd_write_q;
    logic [ADDR_W-1:0]   cmd_addr_q;
    logic [DATA_W-1:0]   cmd_data_q;
    logic [DATA_W-1:0]   rsp_hold_q;
    logic                rsp_flag_q;
    logic                overflow_q;
    logic                len_err_q;

    logic capture_c, shift_c, accept_c, update_c;
    logic load_c, ovf_set_c, len_set_c;

    assign capture_c = jce1 & ~jshift;
    assign shift_c   = jce1 & jshift;
    assign accept_c  = cmd_valid_q & bus.cmd_ready;

    // Status word presented to the host at capture
    always_comb begin
        cap_word                      = '0;
        cap_word[DATA_W-1:0]          = rsp_hold_q;
        cap_word[DATA_W + FLAG_RSP]   = rsp_flag_q;
        cap_word[DATA_W + FLAG_PEND]  = cmd_valid_q;
        cap_word[DATA_W + FLAG_OVF]   = overflow_q;
        cap_word[DATA_W + FLAG_LEN]   = len_err_q;
    end

    jtag_er1_shreg #(
        .FRAME_W (FRAME_W),
        .CNT_W   (CNT_W)
    ) u_shreg (
        .clk      (jtck),
        .rst_n    (jrstn),
        .capture  (capture_c),
        .load     (cap_word),
        .shift_en (shift_c),
        .tdi      (jtdi),
        .sr       (sr),
        .count    (count)
    );

    assign jtdo1 = sr[0];

    always_ff @(posedge jtck or negedge jrstn) begin
        if (!jrstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Scan FSM and update decode; an accept in the same cycle frees the slot first
    always_comb begin
        state_d   = state_q;
        update_c  = 1'b0;
        load_c    = 1'b0;
        ovf_set_c = 1'b0;
        len_set_c = 1'b0;
        if (capture_c) begin
            state_d = CAPT;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                CAPT: begin
                    if (jupdate) begin
                        state_d  = IDLE;
                        update_c = 1'b1;
                    end else if (shift_c) begin
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (jupdate) begin
                        state_d  = IDLE;
                        update_c = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (update_c) begin
            if (count == CNT_FULL) begin
                if (cmd_valid_q && !accept_c) begin
                    ovf_set_c = 1'b1;
                end else begin
                    load_c = 1'b1;
                end
            end else if (count != '0) begin
                len_set_c = 1'b1;
            end
        end
    end

    always_ff @(posedge jtck or negedge jrstn) begin
        if (!jrstn) begin
            cmd_valid_q <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
        end else if (load_c) begin
            cmd_valid_q <= 1'b1;
            cmd_write_q <= sr[FRAME_W-1];
            cmd_addr_q  <= sr[FRAME_W-2:DATA_W];
            cmd_data_q  <= sr[DATA_W-1:0];
        end else if (accept_c) begin
            cmd_valid_q <= 1'b0;
        end
    end

    // Sticky flags are read-cleared by capture; a same-cycle response still sets rsp_flag
    always_ff @(posedge jtck or negedge jrstn) begin
        if (!jrstn) begin
            rsp_hold_q <= '0;
            rsp_flag_q <= 1'b0;
            overflow_q <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            if (bus.rsp_valid) begin
                rsp_hold_q <= bus.rsp_data;
                rsp_flag_q <= 1'b1;
            end else if (capture_c) begin
                rsp_flag_q <= 1'b0;
            end
            if (capture_c) begin
                overflow_q <= 1'b0;
                len_err_q  <= 1'b0;
            end else begin
                if (ovf_set_c) overflow_q <= 1'b1;
                if (len_set_c) len_err_q  <= 1'b1;
            end
        end
    end

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_write = cmd_write_q;
    assign bus.cmd_addr  = cmd_addr_q;
    assign bus.cmd_data  = cmd_data_q;

endmodule

// File: tb/tb_jtag_er1_mailbox.sv
// Directed bench for jtag_er1_mailbox: scans frames through ER1 and checks commands and status readback.
module tb_jtag_er1_mailbox;

    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned DATA_W  = 24;
    localparam int unsigned FRAME_W = 32;

    logic jtck = 1'b0;
    logic jrstn, jtdi, jshift, jupdate, jce1, jtdo1;
    int   errors = 0;
    int   checks = 0;

    jtag_er1_mailbox_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mb ();

    jtag_er1_mailbox #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .jtck    (jtck),
        .jrstn   (jrstn),
        .jtdi    (jtdi),
        .jshift  (jshift),
        .jupdate (jupdate),
        .jce1    (jce1),
        .jtdo1   (jtdo1),
        .bus     (mb)
    );

    always #5 jtck = ~jtck;

    // Capture, shift nbits of din (LSB first) while collecting TDO, optionally update
    task automatic scan(input logic [FRAME_W-1:0] din, input int nbits, input bit upd,
                        input bit rdy_upd, output logic [FRAME_W-1:0] dout);
        dout = '0;
        @(negedge jtck);
        jce1 = 1'b1; jshift = 1'b0;
        @(negedge jtck);
        if (nbits == 0) begin
            jce1 = 1'b0;
        end else begin
            jshift = 1'b1;
        end
        for (int i = 0; i < nbits; i++) begin
            jtdi    = din[i];
            dout[i] = jtdo1;
            @(negedge jtck);
        end
        jce1 = 1'b0; jshift = 1'b0; jtdi = 1'b0;
        if (upd) begin
            jupdate      = 1'b1;
            mb.cmd_ready = rdy_upd;
            @(negedge jtck);
            jupdate      = 1'b0;
            mb.cmd_ready = 1'b0;
        end
        @(negedge jtck);
    endtask

    task automatic test_reset();
        jrstn = 1'b0;
        jtdi = 0; jshift = 0; jupdate = 0; jce1 = 0;
        mb.cmd_ready = 0; mb.rsp_valid = 0; mb.rsp_data = '0;
        repeat (2) @(negedge jtck);
        checks++; if (jtdo1 !== 1'b0) begin errors++; $display("FAIL reset_tdo: got %b expected 0", jtdo1); end
        checks++; if (mb.cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", mb.cmd_valid); end
        checks++; if ({mb.cmd_write, mb.cmd_addr, mb.cmd_data} !== 32'h0) begin
            errors++; $display("FAIL reset_cmd: got %h expected 00000000", {mb.cmd_write, mb.cmd_addr, mb.cmd_data});
        end
        jrstn = 1'b1;
        @(negedge jtck);
    endtask

    task automatic test_zero_scan();
        logic [FRAME_W-1:0] d;
        scan(32'h0, 32, 1'b0, 1'b0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL zero_tdo: got %h expected 00000000", d); end
        checks++; if (mb.cmd_valid !== 1'b0) begin errors++; $display("FAIL zero_valid: got %b expected 0", mb.cmd_valid); end
    endtask

    task automatic test_command();
        logic [FRAME_W-1:0] d;
        scan(32'h8A12_3456, 32, 1'b1, 1'b0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL cmd_status: got %h expected 00000000", d); end
        checks++; if (mb.cmd_valid !== 1'b1) begin errors++; $display("FAIL cmd_valid: got %b expected 1", mb.cmd_valid); end
        checks++; if (mb.cmd_write !== 1'b1) begin errors++; $display("FAIL cmd_write: got %b expected 1", mb.cmd_write); end
        checks++; if (mb.cmd_addr !== 7'h0A) begin errors++; $display("FAIL cmd_addr: got %h expected 0a", mb.cmd_addr); end
        checks++; if (mb.cmd_data !== 24'h123456) begin errors++; $display("FAIL cmd_data: got %h expected 123456", mb.cmd_data); end
        repeat (3) @(negedge jtck);
        checks++; if (mb.cmd_valid !== 1'b1 || mb.cmd_data !== 24'h123456) begin
            errors++; $display("FAIL cmd_hold: got valid=%b data=%h expected valid=1 data=123456", mb.cmd_valid, mb.cmd_data);
        end
    endtask

    task automatic test_overflow();
        logic [FRAME_W-1:0] d;
        scan(32'h0100_0055, 32, 1'b1, 1'b0, d);
        checks++; if (d !== 32'h0200_0000) begin errors++; $display("FAIL ovf_pend_read: got %h expected 02000000", d); end
        checks++; if (mb.cmd_addr !== 7'h0A || mb.cmd_data !== 24'h123456 || mb.cmd_write !== 1'b1) begin
            errors++; $display("FAIL ovf_cmd_kept: got %b/%h/%h expected 1/0a/123456", mb.cmd_write, mb.cmd_addr, mb.cmd_data);
        end
        scan(32'h0, 32, 1'b0, 1'b0, d);
        checks++; if (d !== 32'h0600_0000) begin errors++; $display("FAIL ovf_flags: got %h expected 06000000", d); end
        scan(32'h0, 32, 1'b0, 1'b0, d);
        checks++; if (d !== 32'h0200_0000) begin errors++; $display("FAIL ovf_cleared: got %h expected 02000000", d); end
        mb.cmd_ready = 1'b1;
        @(negedge jtck);
        mb.cmd_ready = 1'b0;
        checks++; if (mb.cmd_valid !== 1'b0) begin errors++; $display("FAIL accept: got %b expected 0", mb.cmd_valid); end
    endtask

    task automatic test_len_err();
        logic [FRAME_W-1:0] d;
        scan(32'h0000_0077, 31, 1'b1, 1'b0, d);
        checks++; if (mb.cmd_valid !== 1'b0) begin errors++; $display("FAIL len_no_cmd: got %b expected 0", mb.cmd_valid); end
        scan(32'h0, 32, 1'b0, 1'b0, d);
        checks++; if (d !== 32'h0800_0000) begin errors++; $display("FAIL len_flag: got %h expected 08000000", d); end
        scan(32'h0, 32, 1'b0, 1'b0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL len_cleared: got %h expected 00000000", d); end
    endtask

    task automatic test_response();
        logic [FRAME_W-1:0] d;
        @(negedge jtck);
        mb.rsp_valid = 1'b1; mb.rsp_data = 24'hABCDEF;
        @(negedge jtck);
        mb.rsp_valid = 1'b0; mb.rsp_data = '0;
        scan(32'h0, 32, 1'b0, 1'b0, d);
        checks++; if (d !== 32'h01AB_CDEF) begin errors++; $display("FAIL rsp_read: got %h expected 01abcdef", d); end
        scan(32'h0, 32, 1'b0, 1'b0, d);
        checks++; if (d !== 32'h00AB_CDEF) begin errors++; $display("FAIL rsp_reread: got %h expected 00abcdef", d); end
    endtask

    task automatic test_back_to_back();
        logic [FRAME_W-1:0] d;
        scan(32'h0500_0011, 32, 1'b1, 1'b0, d);
        checks++; if (mb.cmd_valid !== 1'b1 || mb.cmd_addr !== 7'h05 || mb.cmd_data !== 24'h000011 || mb.cmd_write !== 1'b0) begin
            errors++; $display("FAIL b2b_first: got %b/%b/%h/%h expected 1/0/05/000011", mb.cmd_valid, mb.cmd_write, mb.cmd_addr, mb.cmd_data);
        end
        scan(32'h8100_0022, 32, 1'b1, 1'b1, d);
        checks++; if (d !== 32'h02AB_CDEF) begin errors++; $display("FAIL b2b_status: got %h expected 02abcdef", d); end
        checks++; if (mb.cmd_valid !== 1'b1 || mb.cmd_addr !== 7'h01 || mb.cmd_data !== 24'h000022 || mb.cmd_write !== 1'b1) begin
            errors++; $display("FAIL b2b_second: got %b/%b/%h/%h expected 1/1/01/000022", mb.cmd_valid, mb.cmd_write, mb.cmd_addr, mb.cmd_data);
        end
        scan(32'h0, 32, 1'b0, 1'b0, d);
        checks++; if (d !== 32'h02AB_CDEF) begin errors++; $display("FAIL b2b_no_ovf: got %h expected 02abcdef", d); end
    endtask

    task automatic test_reset_mid_scan();
        logic [FRAME_W-1:0] din;
        logic [FRAME_W-1:0] d;
        din = 32'hFFFF_FFFF;
        @(negedge jtck);
        jce1 = 1'b1; jshift = 1'b0;
        @(negedge jtck);
        jshift = 1'b1;
        for (int i = 0; i < 17; i++) begin
            jtdi = din[i];
            @(negedge jtck);
        end
        jrstn = 1'b0;
        #1;
        checks++; if (jtdo1 !== 1'b0 || mb.cmd_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_out: got tdo=%b valid=%b expected 0/0", jtdo1, mb.cmd_valid);
        end
        checks++; if ({mb.cmd_write, mb.cmd_addr, mb.cmd_data} !== 32'h0) begin
            errors++; $display("FAIL rst_mid_cmd: got %h expected 00000000", {mb.cmd_write, mb.cmd_addr, mb.cmd_data});
        end
        @(negedge jtck);
        jrstn = 1'b1;
        for (int i = 17; i < 32; i++) begin
            jtdi = din[i];
            @(negedge jtck);
        end
        jce1 = 1'b0; jshift = 1'b0; jtdi = 1'b0; jupdate = 1'b1;
        @(negedge jtck);
        jupdate = 1'b0;
        @(negedge jtck);
        checks++; if (mb.cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_nocmd: got %b expected 0", mb.cmd_valid); end
        scan(32'h0, 32, 1'b0, 1'b0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_status: got %h expected 00000000", d); end
    endtask

    initial begin
        test_reset();
        test_zero_scan();
        test_command();
        test_overflow();
        test_len_err();
        test_response();
        test_back_to_back();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
